// File: rtl/cdc_sync_pkg.sv
// Shared types and helpers for the mux-recirculation synchronizer.
package cdc_sync_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    SETTLE = 4'b0010,
    LOAD   = 4'b0100,
    ACK    = 4'b1000
  } state_e;

  localparam int unsigned ST_LOAD_BIT = 2;
  localparam int unsigned ST_ACK_BIT  = 3;

  // Settle counter width: clog2(max(settle_cycles,1)) + 1.
  function automatic int unsigned settle_cnt_width(input int unsigned settle_cycles);
    int unsigned m;
    m = (settle_cycles > 0) ? settle_cycles : 1;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/mux_recirc_load_ctrl.sv
// Destination-side controller for the mux-recirculation synchronizer: drives the
// external mux select, owns the holding register and runs the 4-phase handshake.
module mux_recirc_load_ctrl
  import cdc_sync_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned COUNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_sync,
  input  logic [DATA_WIDTH-1:0]  mux_z,
  output logic                   mux_sel,
  output logic [DATA_WIDTH-1:0]  hold_q,
  output logic                   ack,
  output logic                   data_valid,
  output logic                   abort_err,
  output logic [COUNT_WIDTH-1:0] xfer_count
);

  localparam int unsigned CNT_W       = settle_cnt_width(SETTLE_CYCLES);
  localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  hold_d;
  logic                   data_valid_q, data_valid_d;
  logic                   abort_err_q, abort_err_d;
  logic [COUNT_WIDTH-1:0] xfer_count_q, xfer_count_d;

  // Select and ack are the one-hot state flops themselves, so they cannot glitch.
  assign mux_sel    = state_q[ST_LOAD_BIT];
  assign ack        = state_q[ST_ACK_BIT];
  assign data_valid = data_valid_q;
  assign abort_err  = abort_err_q;
  assign xfer_count = xfer_count_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_d       = mux_z;
    data_valid_d = 1'b0;
    abort_err_d  = 1'b0;
    xfer_count_d = xfer_count_q;
    unique case (state_q)
      IDLE: begin
        if (req_sync) begin
          cnt_d = '0;
          if (SETTLE_CYCLES == 0) state_d = LOAD;
          else                    state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (!req_sync) begin
          state_d     = IDLE;
          abort_err_d = 1'b1;
          cnt_d       = '0;
        end else if (cnt_q == CNT_W'(SETTLE_LAST)) begin
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // The edge leaving LOAD captures the bus; a req drop here is ignored.
      LOAD: begin
        state_d      = ACK;
        data_valid_d = 1'b1;
        xfer_count_d = xfer_count_q + COUNT_WIDTH'(1);
      end
      ACK: begin
        if (!req_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hold_q       <= '0;
      data_valid_q <= 1'b0;
      abort_err_q  <= 1'b0;
      xfer_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      data_valid_q <= data_valid_d;
      abort_err_q  <= abort_err_d;
      xfer_count_q <= xfer_count_d;
    end
  end

endmodule

// File: tb/tb_mux_recirc_load_ctrl.sv
// Bench for mux_recirc_load_ctrl: three instances (S=2, S=4, S=0 with 2-bit count)
// each wrapped by a behavioural mux, checked by directed tables and a timestamp model.
module tb_mux_recirc_load_ctrl;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 8;
  localparam int unsigned S_TAB  [N] = '{2, 4, 0};
  localparam int unsigned CW_TAB [N] = '{16, 16, 2};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          req [N];
  logic [DW-1:0] bus [N];
  logic [DW-1:0] mz  [N];
  logic [DW-1:0] hq  [N];
  logic          sel [N];
  logic          ak  [N];
  logic          dv  [N];
  logic          ab  [N];
  logic [15:0]   cnt [N];

  int tests = 0;
  int fails = 0;

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_dut
      logic [CW_TAB[g]-1:0] cnt_raw;
      assign mz[g]  = sel[g] ? bus[g] : hq[g];
      assign cnt[g] = 16'(cnt_raw);
      mux_recirc_load_ctrl #(
        .DATA_WIDTH   (DW),
        .SETTLE_CYCLES(S_TAB[g]),
        .COUNT_WIDTH  (CW_TAB[g])
      ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_sync  (req[g]),
        .mux_z     (mz[g]),
        .mux_sel   (sel[g]),
        .hold_q    (hq[g]),
        .ack       (ak[g]),
        .data_valid(dv[g]),
        .abort_err (ab[g]),
        .xfer_count(cnt_raw)
      );
    end
  endgenerate

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a transfer accepted at edge t0 loads at edge t0+S+1 unless
  // req is seen low on any of edges t0+1..t0+S, which aborts it.
  int          n_edge;
  int          m_mode [N];   // 0 idle, 1 request accepted, 2 acknowledged
  int          m_t0   [N];
  logic [7:0]  m_hold [N];
  int          m_cnt  [N];
  logic        m_dv   [N];
  logic        m_ab   [N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_edge = 0;
      for (int i = 0; i < N; i++) begin
        m_mode[i] = 0; m_t0[i] = 0; m_hold[i] = '0; m_cnt[i] = 0; m_dv[i] = 0; m_ab[i] = 0;
      end
    end else begin
      n_edge++;
      for (int i = 0; i < N; i++) begin
        m_dv[i] = 0;
        m_ab[i] = 0;
        case (m_mode[i])
          0: if (req[i]) begin m_mode[i] = 1; m_t0[i] = n_edge; end
          1: begin
            if (n_edge == m_t0[i] + int'(S_TAB[i]) + 1) begin
              m_hold[i] = bus[i];
              m_cnt[i]  = (m_cnt[i] + 1) % (1 << CW_TAB[i]);
              m_dv[i]   = 1;
              m_mode[i] = 2;
            end else if (!req[i]) begin
              m_ab[i]   = 1;
              m_mode[i] = 0;
            end
          end
          default: if (!req[i]) m_mode[i] = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("model sel[%0d]", i), 32'(sel[i]),
            32'(m_mode[i] == 1 && n_edge == m_t0[i] + int'(S_TAB[i])));
        chk($sformatf("model hold[%0d]", i), 32'(hq[i]), 32'(m_hold[i]));
        chk($sformatf("model ack[%0d]", i), 32'(ak[i]), 32'(m_mode[i] == 2));
        chk($sformatf("model dv[%0d]", i), 32'(dv[i]), 32'(m_dv[i]));
        chk($sformatf("model abort[%0d]", i), 32'(ab[i]), 32'(m_ab[i]));
        chk($sformatf("model cnt[%0d]", i), 32'(cnt[i]), 32'(m_cnt[i]));
      end
    end
  end

  typedef struct {
    logic        req;
    logic [7:0]  bus;
    logic        e_sel;
    logic [7:0]  e_hold;
    logic        e_ack;
    logic        e_dv;
    logic [15:0] e_cnt;
  } vec_t;

  task automatic handshake(input int i, input logic [7:0] d, output logic [15:0] c);
    int k;
    @(negedge clk);
    bus[i] = d;
    req[i] = 1'b1;
    k = 0;
    while (!ak[i] && k < 40) begin @(negedge clk); k++; end
    chk($sformatf("hs ack rise[%0d]", i), 32'(ak[i]), 32'd1);
    c = cnt[i];
    req[i] = 1'b0;
    k = 0;
    while (ak[i] && k < 40) begin @(negedge clk); k++; end
    chk($sformatf("hs ack fall[%0d]", i), 32'(ak[i]), 32'd0);
  endtask

  initial begin
    vec_t        tbl [8];
    logic [7:0]  h_before;
    logic [15:0] c_before;
    logic [15:0] c_got;
    int          wexp [5];

    tbl[0] = '{1'b0, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0};
    tbl[1] = '{1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0};
    tbl[2] = '{1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0};
    tbl[3] = '{1'b1, 8'h3C, 1'b1, 8'h00, 1'b0, 1'b0, 16'd0};
    tbl[4] = '{1'b1, 8'h3C, 1'b0, 8'h3C, 1'b1, 1'b1, 16'd1};
    tbl[5] = '{1'b1, 8'h3C, 1'b0, 8'h3C, 1'b1, 1'b0, 16'd1};
    tbl[6] = '{1'b0, 8'hFF, 1'b0, 8'h3C, 1'b0, 1'b0, 16'd1};
    tbl[7] = '{1'b0, 8'hFF, 1'b0, 8'h3C, 1'b0, 1'b0, 16'd1};
    wexp[0] = 1; wexp[1] = 2; wexp[2] = 3; wexp[3] = 0; wexp[4] = 1;

    for (int i = 0; i < N; i++) begin req[i] = 1'b0; bus[i] = '0; end
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("reset hold[%0d]", i), 32'(hq[i]), 32'd0);
      chk($sformatf("reset sel[%0d]", i), 32'(sel[i]), 32'd0);
      chk($sformatf("reset cnt[%0d]", i), 32'(cnt[i]), 32'd0);
    end
    #2 rst_n = 1'b1;

    // Basic S=2 transfer as a table of per-cycle expectations.
    for (int i = 0; i < 8; i++) begin
      req[0] = tbl[i].req;
      bus[0] = tbl[i].bus;
      @(negedge clk);
      chk($sformatf("tbl%0d sel", i),  32'(sel[0]), 32'(tbl[i].e_sel));
      chk($sformatf("tbl%0d hold", i), 32'(hq[0]),  32'(tbl[i].e_hold));
      chk($sformatf("tbl%0d ack", i),  32'(ak[0]),  32'(tbl[i].e_ack));
      chk($sformatf("tbl%0d dv", i),   32'(dv[0]),  32'(tbl[i].e_dv));
      chk($sformatf("tbl%0d cnt", i),  32'(cnt[0]), 32'(tbl[i].e_cnt));
    end

    // Bus changes with req low must not reach the holding register.
    repeat (20) begin
      @(negedge clk);
      chk("hold value", 32'(hq[0]), 32'h3C);
      chk("hold sel", 32'(sel[0]), 32'd0);
    end

    // Abort on S=4: req high for two edges only.
    h_before = hq[1];
    c_before = cnt[1];
    req[1] = 1'b1;
    @(negedge clk); chk("abort sel e0", 32'(sel[1]), 32'd0);
    @(negedge clk); chk("abort sel e1", 32'(sel[1]), 32'd0);
    req[1] = 1'b0;
    @(negedge clk);
    chk("abort pulse", 32'(ab[1]), 32'd1);
    chk("abort sel e2", 32'(sel[1]), 32'd0);
    @(negedge clk);
    chk("abort single", 32'(ab[1]), 32'd0);
    chk("abort hold", 32'(hq[1]), 32'(h_before));
    chk("abort cnt", 32'(cnt[1]), 32'(c_before));

    // S=0: select in the cycle right after the accepting edge.
    bus[2] = 8'h5A;
    req[2] = 1'b1;
    @(negedge clk); chk("s0 sel", 32'(sel[2]), 32'd1);
    @(negedge clk);
    chk("s0 hold", 32'(hq[2]), 32'h5A);
    chk("s0 dv", 32'(dv[2]), 32'd1);
    chk("s0 ack", 32'(ak[2]), 32'd1);
    chk("s0 sel off", 32'(sel[2]), 32'd0);
    req[2] = 1'b0;
    @(negedge clk); chk("s0 ack drop", 32'(ak[2]), 32'd0);

    // Asynchronous reset while acknowledging 0xA5.
    bus[0] = 8'hA5;
    req[0] = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre-reset hold", 32'(hq[0]), 32'hA5);
    chk("pre-reset ack", 32'(ak[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("async hold[%0d]", i), 32'(hq[i]), 32'd0);
      chk($sformatf("async ack[%0d]", i), 32'(ak[i]), 32'd0);
      chk($sformatf("async sel[%0d]", i), 32'(sel[i]), 32'd0);
      chk($sformatf("async dv[%0d]", i), 32'(dv[i]), 32'd0);
      chk($sformatf("async abort[%0d]", i), 32'(ab[i]), 32'd0);
      chk($sformatf("async cnt[%0d]", i), 32'(cnt[i]), 32'd0);
    end
    req[0] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;

    // 2-bit counter wrap across five legal handshakes.
    for (int k = 0; k < 5; k++) begin
      handshake(2, 8'(k * 17 + 3), c_got);
      chk($sformatf("wrap cnt #%0d", k), 32'(c_got), 32'(wexp[k]));
    end

    // Random req/bus activity on all instances, checked by the model each cycle.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
        bus[i] = 8'($urandom);
      end
    end
    for (int i = 0; i < N; i++) req[i] = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_recirc_load_ctrl.md
Name: mux_recirc_load_ctrl

Overview:
- Destination-domain controller for the mux-recirculation synchronizer.
- Sits directly around mux_2_to_1:
  - drives the mux select (mux_sel -> sel);
  - owns the holding register (hold_q -> mux input a; mux output z -> mux_z).
- Mux input b carries the unsynchronized source bus.
- Runs a 4-phase req/ack handshake against an already-synchronized request. Loads the bus only after a programmable settle time, then returns ack.

Parameters:
- DATA_WIDTH, 8, bus width; matches the INPUT_BIT_LENGTH of the attached mux; must be >= 1.
- SETTLE_CYCLES, 2, cycles req_sync must stay high before load; 0 allowed (no settle wait).
- COUNT_WIDTH, 16, width of the completed-transfer counter.

Ports:
- clk  input  1  destination clock
- rst_n  input  1  asynchronous active-low reset
- req_sync  input  1  source request, already synchronized into clk domain (level, 4-phase)
- mux_z  input  DATA_WIDTH  output of external mux_2_to_1
- mux_sel  output  1  select to mux (1 = take source bus b)
- hold_q  output  DATA_WIDTH  holding register; feeds mux input a and downstream logic
- ack  output  1  acknowledge level back to source (synchronized by source side)
- data_valid  output  1  one-cycle pulse: hold_q contains a newly captured word
- abort_err  output  1  one-cycle pulse: req_sync dropped before load
- xfer_count  output  COUNT_WIDTH  number of completed loads, wraps modulo 2^COUNT_WIDTH

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous and active-low (clk, rst_n).
  - rst_n low immediately forces: state IDLE, settle counter 0, mux_sel 0, hold_q 0, ack 0, data_valid 0, abort_err 0, xfer_count 0.
- Holding register:
  - hold_q <= mux_z every clock edge.
  - Recirculation happens through the external mux: with mux_sel=0, mux_z == hold_q, so the value holds.
- States: IDLE, SETTLE, LOAD, ACK. Encoding is one-hot. mux_sel is the LOAD state flop itself (registered, glitch-free); ack is the ACK state flop.
- IDLE:
  - req_sync=1 -> SETTLE with cnt=0, or -> LOAD directly if SETTLE_CYCLES=0.
  - req_sync=0 -> stay.
- SETTLE:
  - cnt increments each cycle.
  - req_sync=0 -> IDLE, abort_err pulses 1 cycle, no load.
  - Otherwise, when cnt==SETTLE_CYCLES-1 -> LOAD.
- LOAD:
  - Lasts exactly 1 cycle; mux_sel=1 during it.
  - The hold_q edge ending LOAD captures the source bus.
  - Next state is ACK unconditionally; a req drop here is ignored because the data is already captured.
- ACK:
  - ack=1.
  - data_valid=1 only in the first ACK cycle.
  - xfer_count increments once on entry.
  - Stay while req_sync=1; req_sync=0 -> IDLE, ack=0 the following cycle.
- Latency:
  - req_sync sampled high at edge E0 puts the FSM in SETTLE.
  - LOAD occupies cycle E0+S to E0+S+1 (S = SETTLE_CYCLES).
  - hold_q, ack and data_valid are all valid at edge E0+S+1.
  - With S=0: LOAD immediately after E0; hold_q valid at E0+1.
- Ordering rules:
  - A new request is only accepted from IDLE. req_sync must be observed low (ACK -> IDLE) before the next rise is honoured.
  - A req that stays high after ACK->IDLE cannot occur in a legal 4-phase protocol; if it does, IDLE re-arms (treated as a new request).
- Reset mid-transfer: returns to IDLE, hold_q cleared, ack dropped. The source must restart its handshake.
- xfer_count overflow: wraps from all-ones to 0 with no flag.

Decomposition:
- Shared package cdc_sync_pkg holds:
  - the state enum typedef (IDLE, SETTLE, LOAD, ACK, one-hot);
  - a function computing the settle-counter width as clog2(max(SETTLE_CYCLES,1))+1.
- No sub-module. mux_2_to_1 stays external, instantiated by the parent synchronizer wrapper. The bench instantiates it alongside this block.

Test Plan:
- Reset: rst_n low mid-ACK with hold_q=0xA5 -> all outputs 0 asynchronously, before the next clk edge.
- Basic transfer, S=2, bus=0x3C: req_sync rises at E0 -> mux_sel high for exactly one cycle; at E0+3 hold_q=0x3C, data_valid=1 for one cycle, ack=1, xfer_count=1. Then drop req -> ack=0 one cycle later.
- Hold: after the transfer, change bus to 0xFF with req low for 20 cycles -> hold_q stays 0x3C, mux_sel stays 0.
- Abort: S=4, req high for 2 cycles then low -> abort_err single pulse, no mux_sel, hold_q unchanged, xfer_count unchanged.
- S=0: req rise at E0 -> mux_sel in the following cycle, hold_q=bus at E0+1.
- Wrap: COUNT_WIDTH=2, 5 back-to-back legal handshakes -> xfer_count goes 1,2,3,0,1.
